// File: rtl/cipher_share_ctrl_if.sv
// Bundle of every non-clock/reset signal around the shared cipher controller:
// key management, two requesters, the cipher core side, the response port
// and debug visibility. The controller takes the slave view, the environment
// takes the master view.
//
// Handshake rule for all valid/ready pairs here: a transfer happens on a
// rising clk edge where both valid and ready are high. The response side holds
// resp_valid/resp_data/resp_id stable until resp_ready is seen.
interface cipher_share_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic              key_wr_en;
    logic [DATA_W-1:0] key_wr_data;
    logic              key_lock;
    logic              key_err;

    logic              req0_valid;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;

    logic              core_start;
    logic [DATA_W-1:0] core_data_in;
    logic [DATA_W-1:0] core_key;
    logic [DATA_W-1:0] core_data_out;

    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              resp_id;
    logic              resp_ready;

    logic [CNT_W-1:0]  txn_count;
    logic [1:0]        state_dbg;

    modport slave (
        input  key_wr_en, key_wr_data, key_lock,
        output key_err,
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready,
        output core_start, core_data_in, core_key,
        input  core_data_out,
        output resp_valid, resp_data, resp_id,
        input  resp_ready,
        output txn_count, state_dbg
    );

    modport master (
        output key_wr_en, key_wr_data, key_lock,
        input  key_err,
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready,
        input  core_start, core_data_in, core_key,
        output core_data_out,
        input  resp_valid, resp_data, resp_id,
        output resp_ready,
        input  txn_count, state_dbg
    );
endinterface

// File: rtl/cipher_share_ctrl.sv
// Round-robin sharing of one registered XOR cipher core between two
// requesters. One transaction at a time: accept, issue to the core, capture
// the core result, then hold it on the response port until taken. The block
// also owns the core key register (write-lockable, zero keys rejected) and a
// saturating count of completed transactions.
module cipher_share_ctrl #(
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] KEY_RST = 8'h42,
    parameter int                CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    cipher_share_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] key_q;
    logic              lock_q;
    logic              rr_q;        // 1: req1 wins the next tie
    logic [DATA_W-1:0] cap_data_q;
    logic              cap_id_q;
    logic [DATA_W-1:0] resp_data_q;
    logic [CNT_W-1:0]  txn_q;
    logic              key_err_q;
    logic              grant0, grant1;
    logic              key_wr_ok;

    // Key writes only land between transactions, while unlocked, and never as zero.
    assign key_wr_ok = bus.key_wr_en && (state_q == S_IDLE) && !lock_q
                       && (bus.key_wr_data != '0);

    // Next-state and grant decode; grants can only be raised while idle.
    always_comb begin
        state_d = state_q;
        grant0  = 1'b0;
        grant1  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req0_valid && (!bus.req1_valid || !rr_q)) begin
                    grant0 = 1'b1;
                end else if (bus.req1_valid) begin
                    grant1 = 1'b1;
                end
                if (grant0 || grant1) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  state_d = S_RESP;
            S_RESP: begin
                if (bus.resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Key register, sticky lock and one-cycle rejection pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            key_q     <= KEY_RST;
            lock_q    <= 1'b0;
            key_err_q <= 1'b0;
        end else begin
            key_err_q <= bus.key_wr_en && !key_wr_ok;
            if (key_wr_ok) begin
                key_q <= bus.key_wr_data;
            end
            if (bus.key_lock) begin
                lock_q <= 1'b1;
            end
        end
    end

    // Request capture, round-robin pointer and core result capture.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_q        <= 1'b0;
            cap_data_q  <= '0;
            cap_id_q    <= 1'b0;
            resp_data_q <= '0;
        end else begin
            if (grant0 || grant1) begin
                cap_data_q <= grant1 ? bus.req1_data : bus.req0_data;
                cap_id_q   <= grant1;
                rr_q       <= grant0;
            end
            if (state_q == S_WAIT) begin
                resp_data_q <= bus.core_data_out;
            end
        end
    end

    // Completed-transaction counter, sticks at all-ones.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            txn_q <= '0;
        end else if ((state_q == S_RESP) && bus.resp_ready
                     && (txn_q != {CNT_W{1'b1}})) begin
            txn_q <= txn_q + 1'b1;
        end
    end

    assign bus.req0_ready   = grant0 && reset_n;
    assign bus.req1_ready   = grant1 && reset_n;
    assign bus.core_start   = (state_q == S_ISSUE);
    assign bus.core_data_in = (state_q == S_ISSUE) ? cap_data_q : '0;
    assign bus.core_key     = key_q;
    assign bus.resp_valid   = (state_q == S_RESP);
    assign bus.resp_data    = resp_data_q;
    assign bus.resp_id      = cap_id_q;
    assign bus.key_err      = key_err_q;
    assign bus.txn_count    = txn_q;
    assign bus.state_dbg    = state_q;
endmodule

// File: tb/tb_cipher_share_ctrl.sv
// Bench for cipher_share_ctrl: directed scenarios plus a random phase. A
// behavioural model tracks "a transaction is outstanding", the key, the lock
// and the count from the transaction-level rules, and a monitor compares
// every cycle; expected responses live in a queue popped on each response.
module tb_cipher_share_ctrl;
    localparam int DW      = 8;
    localparam int CW      = 4;
    localparam int CNT_MAX = 15;

    logic clk;
    logic reset_n;
    cipher_share_ctrl_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    cipher_share_ctrl #(.DATA_W(DW), .KEY_RST(8'h42), .CNT_W(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cipher core stand-in: registered XOR.
    logic [DW-1:0] core_q;
    always @(posedge clk) begin
        if (bus.core_start) core_q <= bus.core_data_in ^ bus.core_key;
    end
    assign bus.core_data_out = core_q;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model + monitor ----------------
    logic [DW:0]   exp_q[$];    // {id, data}
    logic          busy;
    int            acc_cyc;
    logic [DW-1:0] key_m;
    logic          lock_m;
    int            cnt_m;
    logic          exp_err;
    logic          last_g;
    logic [DW-1:0] cap_m;

    always @(negedge clk) begin
        logic          was_busy, g, e0, e1, nerr, exp_rv, exp_st;
        logic [DW-1:0] nkey, d;
        logic [DW:0]   front;
        cyc++;
        if (!reset_n) begin
            busy = 0; key_m = 8'h42; lock_m = 0; cnt_m = 0;
            exp_err = 0; last_g = 1; exp_q.delete();
        end else begin
            was_busy = busy;
            chk("key_err", bus.key_err, exp_err);
            chk("core_key", bus.core_key, key_m);
            chk("txn_count", bus.txn_count, cnt_m);
            exp_rv = was_busy && (cyc - acc_cyc >= 3);
            exp_st = was_busy && (cyc - acc_cyc == 1);
            chk("resp_valid", bus.resp_valid, exp_rv);
            chk("core_start", bus.core_start, exp_st);
            if (exp_st) chk("core_data_in", bus.core_data_in, cap_m);
            g  = (bus.req0_valid && bus.req1_valid) ? !last_g : bus.req1_valid;
            e0 = !was_busy && (bus.req0_valid || bus.req1_valid) && !g;
            e1 = !was_busy && (bus.req0_valid || bus.req1_valid) && g;
            chk("req0_ready", bus.req0_ready, e0);
            chk("req1_ready", bus.req1_ready, e1);
            if (exp_rv) begin
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", 1, 0);
                end else begin
                    front = exp_q[0];
                    chk("resp_data", bus.resp_data, front[DW-1:0]);
                    chk("resp_id", bus.resp_id, front[DW]);
                    if (bus.resp_ready) begin
                        void'(exp_q.pop_front());
                        if (cnt_m < CNT_MAX) cnt_m++;
                        busy = 0;
                    end
                end
            end
            nerr = 0;
            nkey = key_m;
            if (bus.key_wr_en) begin
                if (!was_busy && !lock_m && bus.key_wr_data != 0) nkey = bus.key_wr_data;
                else nerr = 1;
            end
            if (bus.key_lock) lock_m = 1;
            if (!was_busy && (bus.req0_valid || bus.req1_valid)) begin
                d = g ? bus.req1_data : bus.req0_data;
                exp_q.push_back({g, d ^ nkey});
                cap_m = d; busy = 1; acc_cyc = cyc; last_g = g;
            end
            key_m = nkey;
            exp_err = nerr;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic id, input logic [DW-1:0] d);
        int   n = 0;
        logic got = 0;
        if (id) begin bus.req1_valid = 1; bus.req1_data = d; end
        else    begin bus.req0_valid = 1; bus.req0_data = d; end
        while (!got && n < 100) begin
            @(negedge clk);
            got = id ? bus.req1_ready : bus.req0_ready;
            @(posedge clk); #1;
            n++;
        end
        if (id) bus.req1_valid = 0; else bus.req0_valid = 0;
        if (!got) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_resp(input logic do_chk, input logic eid, input logic [DW-1:0] edata);
        int n = 0;
        @(negedge clk);
        while (!bus.resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.resp_valid) chk("resp_timeout", 0, 1);
        else if (do_chk) begin
            chk("dir_resp_data", bus.resp_data, edata);
            chk("dir_resp_id", bus.resp_id, eid);
        end
        @(posedge clk); #1;
    endtask

    task automatic key_write(input logic [DW-1:0] k);
        bus.key_wr_en = 1; bus.key_wr_data = k;
        tick(1);
        bus.key_wr_en = 0;
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation ran past its time budget");
        n_total++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        int a0, a1, c0;
        logic r0, r1;
        reset_n = 0;
        bus.key_wr_en = 0; bus.key_wr_data = 0; bus.key_lock = 0;
        bus.req0_valid = 0; bus.req0_data = 0;
        bus.req1_valid = 0; bus.req1_data = 0;
        bus.resp_ready = 1;
        tick(3);
        reset_n = 1;
        @(negedge clk);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_core_key", bus.core_key, 8'h42);
        chk("rst_txn_count", bus.txn_count, 0);
        @(posedge clk); #1;

        // Single request through the default key
        send(0, 8'h11);
        wait_resp(1, 0, 8'h53);
        tick(2);

        // Both requesters always valid: grants alternate
        a0 = 0; a1 = 0;
        bus.req0_valid = 1; bus.req0_data = 8'($urandom);
        bus.req1_valid = 1; bus.req1_data = 8'($urandom);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            r0 = bus.req0_ready; r1 = bus.req1_ready;
            @(posedge clk); #1;
            if (r0) begin a0++; bus.req0_data = 8'($urandom); end
            if (r1) begin a1++; bus.req1_data = 8'($urandom); end
        end
        bus.req0_valid = 0; bus.req1_valid = 0;
        chk("rr_balance", (a0 - a1 <= 1 && a1 - a0 <= 1), 1);
        chk("rr_accepts", a0 + a1, 8);
        tick(6);

        // Back-pressure on the response port
        bus.resp_ready = 0;
        send(0, 8'h5E);
        bus.req1_valid = 1; bus.req1_data = 8'h21;
        tick(12);
        c0 = cnt_m;
        bus.resp_ready = 1;
        tick(1);
        @(negedge clk);
        chk("bp_count_step", bus.txn_count, c0 + 1);
        chk("bp_next_grant", bus.req1_ready, 1);
        @(posedge clk); #1;
        bus.req1_valid = 0;
        tick(6);

        // Rejected key write while busy: result uses the old key
        send(1, 8'hA5);
        tick(1);
        key_write(8'h77);
        @(negedge clk);
        chk("busy_key_err", bus.key_err, 1);
        chk("busy_resp_data", bus.resp_data, 8'hA5 ^ 8'h42);
        tick(3);

        // Key write in the same idle cycle as an accept
        bus.req0_valid = 1; bus.req0_data = 8'h0F;
        key_write(8'h5A);
        bus.req0_valid = 0;
        wait_resp(1, 0, 8'h55);
        tick(2);

        // Random traffic, key writes and back-pressure
        for (int i = 0; i < 300; i++) begin
            bus.req0_valid  = 1'($urandom_range(0, 1));
            bus.req0_data   = 8'($urandom);
            bus.req1_valid  = 1'($urandom_range(0, 1));
            bus.req1_data   = 8'($urandom);
            bus.resp_ready  = ($urandom_range(0, 3) != 0);
            bus.key_wr_en   = ($urandom_range(0, 9) == 0);
            bus.key_wr_data = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            tick(1);
        end
        bus.req0_valid = 0; bus.req1_valid = 0; bus.key_wr_en = 0;
        bus.resp_ready = 1;
        tick(6);

        // Zero key, legal key, lock, rejected key
        key_write(8'h00);
        @(negedge clk);
        chk("zero_key_err", bus.key_err, 1);
        @(posedge clk); #1;
        key_write(8'h3C);
        bus.key_lock = 1;
        tick(1);
        bus.key_lock = 0;
        key_write(8'h99);
        @(negedge clk);
        chk("locked_key_err", bus.key_err, 1);
        chk("locked_key", bus.core_key, 8'h3C);
        @(posedge clk); #1;
        send(0, 8'hFF);
        wait_resp(1, 0, 8'hC3);
        tick(2);

        // Reset while a response is pending
        bus.resp_ready = 0;
        send(1, 8'h10);
        wait_resp(0, 0, 0);
        reset_n = 0;
        tick(1);
        reset_n = 1;
        bus.resp_ready = 1;
        @(negedge clk);
        chk("mid_rst_resp_valid", bus.resp_valid, 0);
        chk("mid_rst_key", bus.core_key, 8'h42);
        chk("mid_rst_count", bus.txn_count, 0);
        @(posedge clk); #1;
        key_write(8'h21);
        @(negedge clk);
        chk("unlock_key_err", bus.key_err, 0);
        chk("unlock_key", bus.core_key, 8'h21);
        @(posedge clk); #1;

        // Drive the counter into saturation
        for (int i = 0; i < 18; i++) send(1'(i), 8'($urandom));
        tick(6);
        @(negedge clk);
        chk("sat_count", bus.txn_count, CNT_MAX);
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
